mic_peak_meter: RTL and testbench



---
 rtl/voice_pkg.sv | 16 +
 rtl/tick_edge.sv | 22 ++
 rtl/mic_peak_meter.sv | 82 ++++++++
 tb/tb_mic_peak_meter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/voice_pkg.sv
// rtl/voice_pkg.sv - shared constants and the amplitude helper for the voice meter blocks
package voice_pkg;
  localparam int MIC_W    = 12;
  localparam int AMP_W    = 11;
  localparam int AMP_MAX  = 2047;
  localparam int LEVEL_W  = 4;
  localparam int MIDSCALE = 2048;

  // Distance of a sample from the silence code, clipped to the 11-bit amplitude range
  function automatic logic [AMP_W-1:0] amp_of(input logic [MIC_W-1:0] s,
                                               input logic [MIC_W-1:0] mid);
    logic [MIC_W-1:0] d;
    d = (s >= mid) ? s - mid : mid - s;
    return (d > MIC_W'(AMP_MAX)) ? AMP_W'(AMP_MAX) : d[AMP_W-1:0];
  endfunction
endpackage

// File: rtl/tick_edge.sv
// rtl/tick_edge.sv - two-flop rising-edge detector turning a slow strobe into a one-cycle tick
module tick_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic tick
);
  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= strobe;
      s2 <= s1;
    end
  end

  assign tick = s1 & ~s2;
endmodule

// File: rtl/mic_peak_meter.sv
// rtl/mic_peak_meter.sv - windowed peak amplitude meter for 12-bit mic samples
// Optional VOICE_DECAY_EN: published peak falls by at most DECAY_STEP per window.
module mic_peak_meter
  import voice_pkg::*;
#(
  parameter int WINDOW     = 4000,
  parameter int MIDSCALE   = voice_pkg::MIDSCALE,
  parameter int DECAY_STEP = 128
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               clk20k,
  input  logic [MIC_W-1:0]   mic_in,
  output logic [MIC_W-1:0]   peak,
  output logic [LEVEL_W-1:0] level,
  output logic               level_valid
);
  localparam logic [MIC_W-1:0] MID  = MIC_W'(MIDSCALE);
  localparam logic [15:0]      LAST = 16'(WINDOW - 1);

  if (WINDOW < 2 || WINDOW > 65535 || DECAY_STEP < 0 || DECAY_STEP > AMP_MAX) begin : g_bad_param
    $error("mic_peak_meter: parameter out of range");
  end

  logic             tick;
  logic [15:0]      cnt;
  logic [AMP_W-1:0] run_max;
  logic [AMP_W-1:0] amp;
  logic [AMP_W-1:0] win_pk;
  logic [AMP_W-1:0] next_peak;

  tick_edge u_tick (
    .clk    (CLOCK),
    .rst_n  (RESET_N),
    .strobe (clk20k),
    .tick   (tick)
  );

  assign amp    = amp_of(mic_in, MID);
  assign win_pk = (amp > run_max) ? amp : run_max;

`ifdef VOICE_DECAY_EN
  localparam logic [AMP_W-1:0] DECAY = AMP_W'(DECAY_STEP);
  logic [AMP_W-1:0] decayed;

  always_comb begin
    decayed   = (peak[AMP_W-1:0] > DECAY) ? peak[AMP_W-1:0] - DECAY : '0;
    next_peak = win_pk;
    if (win_pk < peak[AMP_W-1:0]) begin
      next_peak = (win_pk > decayed) ? win_pk : decayed;
    end
  end
`else
  always_comb begin
    next_peak = win_pk;
  end
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt         <= '0;
      run_max     <= '0;
      peak        <= '0;
      level       <= '0;
      level_valid <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      if (tick) begin
        if (cnt == LAST) begin
          cnt         <= '0;
          run_max     <= '0;
          peak        <= {1'b0, next_peak};
          level       <= next_peak[AMP_W-1:AMP_W-LEVEL_W];
          level_valid <= 1'b1;
        end else begin
          cnt     <= cnt + 16'd1;
          run_max <= win_pk;
        end
      end
    end
  end
endmodule

// File: tb/tb_mic_peak_meter.sv
// tb/tb_mic_peak_meter.sv - self-checking bench for mic_peak_meter with a window-level reference model
module tb_mic_peak_meter;
  localparam int WIN = 8;

  logic        clk;
  logic        rst_n;
  logic        clk20k;
  logic [11:0] mic_in;
  logic [11:0] peak;
  logic [3:0]  level;
  logic        level_valid;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_pulses = 0;

  // Reference model state: samples seen this window and the published result
  int m_cnt = 0;
  int m_max = 0;
  int exp_peak = 0;
  int exp_level = 0;
  int exp_valid = 0;

  mic_peak_meter #(.WINDOW(WIN)) dut (
    .CLOCK       (clk),
    .RESET_N     (rst_n),
    .clk20k      (clk20k),
    .mic_in      (mic_in),
    .peak        (peak),
    .level       (level),
    .level_valid (level_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_max = 0;
    exp_peak = 0;
    exp_level = 0;
    exp_valid = 0;
  endtask

  task automatic model_tick(input int v);
    int a;
    int w;
    a = (v >= 2048) ? v - 2048 : 2048 - v;
    if (a > 2047) a = 2047;
    if (a > m_max) m_max = a;
    m_cnt++;
    if (m_cnt == WIN) begin
      w = m_max;
`ifdef VOICE_DECAY_EN
      if (w >= exp_peak) exp_peak = w;
      else exp_peak = (w > exp_peak - 128) ? w : ((exp_peak > 128) ? exp_peak - 128 : 0);
`else
      exp_peak = w;
`endif
      exp_level = exp_peak / 128;
      exp_valid = 1;
      m_cnt = 0;
      m_max = 0;
    end
  endtask

  // One clk20k pulse carrying sample v; high_cycles >= 3
  task automatic send_sample(input int v, input int high_cycles);
    @(negedge clk);
    clk20k = 1'b1;
    mic_in = 12'(v);
    @(posedge clk);
    @(posedge clk);
    #1 model_tick(v);
    @(posedge clk);
    #1 exp_valid = 0;
    repeat (high_cycles - 2) @(negedge clk);
    clk20k = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_window(input int v);
    for (int i = 0; i < WIN; i++) send_sample(v, 3);
  endtask

  // Per-cycle comparison against the model, sampled away from the clock edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("peak", int'(peak), exp_peak);
      check("level", int'(level), exp_level);
      check("level_valid", int'(level_valid), exp_valid);
      if (level_valid) n_pulses++;
    end
  end

  initial begin
    int p0;
    rst_n  = 1'b0;
    clk20k = 1'b0;
    mic_in = 12'd2048;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_peak", int'(peak), 0);
    check("reset_valid", int'(level_valid), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Silence: one pulse, zero peak
    p0 = n_pulses;
    send_window(2048);
    check("silence_pulses", n_pulses - p0, 1);
    check("silence_peak", int'(peak), 0);
    check("silence_level", int'(level), 0);

    // Constant offset of 300
    send_window(2348);
    check("const_peak", int'(peak), 300);
    check("const_level", int'(level), 2);
    check("const_model", exp_peak, 300);

    // Single full-scale sample in a silent window, then a silent window
    send_sample(4095, 3);
    for (int i = 1; i < WIN; i++) send_sample(2048, 3);
    check("spike_peak", int'(peak), 2047);
    check("spike_level", int'(level), 15);
    send_window(2048);
`ifdef VOICE_DECAY_EN
    check("decay_peak", int'(peak), 1919);
    check("decay_level", int'(level), 14);
`else
    check("after_spike_peak", int'(peak), 0);
    check("after_spike_level", int'(level), 0);
`endif

    // Code 0 saturates at 2047
    send_window(0);
    check("sat_peak", int'(peak), 2047);
    check("sat_level", int'(level), 15);

    // Long high time yields one tick only
    p0 = n_pulses;
    send_sample(2148, 50000);
    for (int i = 1; i < WIN - 1; i++) send_sample(2048, 3);
    check("long_high_no_early_pulse", n_pulses - p0, 0);
    send_sample(2048, 3);
    check("long_high_pulses", n_pulses - p0, 1);
`ifdef VOICE_DECAY_EN
    check("long_high_peak", int'(peak), 1919);
`else
    check("long_high_peak", int'(peak), 100);
`endif

    // Reset mid-window discards the partial maximum
    for (int i = 0; i < WIN / 2; i++) send_sample(4095, 3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_peak", int'(peak), 0);
    check("midrst_level", int'(level), 0);
    check("midrst_valid", int'(level_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = n_pulses;
    for (int i = 0; i < WIN - 1; i++) send_sample(2098, 3);
    check("post_rst_no_early_pulse", n_pulses - p0, 0);
    send_sample(2098, 3);
    check("post_rst_pulses", n_pulses - p0, 1);
    check("post_rst_peak", int'(peak), 50);
    check("post_rst_level", int'(level), 0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
